// File: rtl/pair_scheduler.sv
// Operand-fetch sequencer for getAccl: walks every (i,j) body pair, drives the
// position/mass RAM read ports and carries a result tag matched to getAccl latency.
module pair_scheduler #(
  parameter int BODIES          = 512,
  parameter int DATA_WIDTH      = 64,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int ACCEL_LATENCY   = 122
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  output logic                       busy,
  output logic                       done,
  output logic [BODY_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_addr_j,
  input  logic [DATA_WIDTH-1:0]      rd_xi,
  input  logic [DATA_WIDTH-1:0]      rd_yi,
  input  logic [DATA_WIDTH-1:0]      rd_xj,
  input  logic [DATA_WIDTH-1:0]      rd_yj,
  input  logic [DATA_WIDTH-1:0]      rd_mj,
  output logic [DATA_WIDTH-1:0]      x1,
  output logic [DATA_WIDTH-1:0]      y1,
  output logic [DATA_WIDTH-1:0]      x2,
  output logic [DATA_WIDTH-1:0]      y2,
  output logic [DATA_WIDTH-1:0]      m2,
  output logic                       in_valid,
  output logic                       res_valid,
  output logic [BODY_ADDR_WIDTH-1:0] res_i,
  output logic                       res_first,
  output logic                       res_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int CNT_W = (ACCEL_LATENCY < 1) ? 1 : $clog2(ACCEL_LATENCY + 1);
  localparam int TAG_W = BODY_ADDR_WIDTH + 3;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ACCEL_LATENCY);

  state_t state_q, state_d;

  logic [BODY_ADDR_WIDTH:0]   n_q, n_d;
  logic [BODY_ADDR_WIDTH-1:0] i_q, i_d;
  logic [BODY_ADDR_WIDTH-1:0] j_q, j_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       iss_valid_q, iss_valid_d;
  logic [BODY_ADDR_WIDTH-1:0] iss_i_q, iss_i_d;
  logic                       iss_first_q, iss_first_d;
  logic                       iss_last_q, iss_last_d;

  logic [TAG_W-1:0] pipe_q [ACCEL_LATENCY];
  logic [TAG_W-1:0] pipe_d [ACCEL_LATENCY];
  logic [TAG_W-1:0] tag_out;

  logic [BODY_ADDR_WIDTH:0] n_m1, n_m2, i_ext, j_ext;
  logic row_end, last_pair, av, first_flag, last_flag;

  // Pair-walk helpers; first/last skip over the self pair of the row.
  always_comb begin
    n_m1       = n_q - 1'b1;
    n_m2       = n_q - 2'd2;
    i_ext      = {1'b0, i_q};
    j_ext      = {1'b0, j_q};
    row_end    = (j_ext == n_m1);
    last_pair  = row_end && (i_ext == n_m1);
    av         = (state_q == S_ISSUE) && (i_q != j_q);
    first_flag = (i_q == '0) ? (j_q == BODY_ADDR_WIDTH'(1)) : (j_q == '0);
    last_flag  = (i_ext == n_m1) ? (j_ext == n_m2) : (j_ext == n_m1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = (num_bodies == '0) ? S_DRAIN : S_ISSUE;
        S_ISSUE: if (last_pair) state_d = S_DRAIN;
        S_DRAIN: if (cnt_q == DRAIN_LAST) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    n_d   = n_q;
    i_d   = i_q;
    j_d   = j_q;
    cnt_d = cnt_q;
    if (abort) begin
      i_d   = '0;
      j_d   = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_d   = num_bodies;
            i_d   = '0;
            j_d   = '0;
            cnt_d = '0;
          end
        end
        S_ISSUE: begin
          if (row_end) begin
            j_d = '0;
            i_d = last_pair ? '0 : i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
        S_DRAIN: if (cnt_q != DRAIN_LAST) cnt_d = cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Tag fields are zeroed on bubbles so res_* read 0 whenever res_valid is low.
  always_comb begin
    iss_valid_d = av && !abort;
    iss_i_d     = iss_valid_d ? i_q : '0;
    iss_first_d = iss_valid_d && first_flag;
    iss_last_d  = iss_valid_d && last_flag;
    for (int unsigned k = 0; k < ACCEL_LATENCY; k++) begin
      pipe_d[k] = '0;
    end
    if (!abort) begin
      pipe_d[0] = {iss_valid_q, iss_i_q, iss_first_q, iss_last_q};
      for (int unsigned k = 1; k < ACCEL_LATENCY; k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_i_q     <= '0;
      iss_first_q <= 1'b0;
      iss_last_q  <= 1'b0;
      for (int unsigned k = 0; k < ACCEL_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      n_q         <= n_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      iss_valid_q <= iss_valid_d;
      iss_i_q     <= iss_i_d;
      iss_first_q <= iss_first_d;
      iss_last_q  <= iss_last_d;
      for (int unsigned k = 0; k < ACCEL_LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  always_comb begin
    tag_out   = pipe_q[ACCEL_LATENCY-1];
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    rd_addr_i = i_q;
    rd_addr_j = j_q;
    in_valid  = iss_valid_q;
    x1        = rd_xi;
    y1        = rd_yi;
    x2        = rd_xj;
    y2        = rd_yj;
    m2        = rd_mj;
    res_valid = tag_out[TAG_W-1];
    res_i     = tag_out[TAG_W-2:2];
    res_first = tag_out[1];
    res_last  = tag_out[0];
  end

endmodule
